gate_tt_scanner: RTL
====================

// Module: gate_tt_scanner
//
// PURPOSE
// Controller that sequences a 2-input combinational gate under test (x, y -> z).
// Steps the gate through every input vector in binary order, waits a settle time,
// samples z, assembles the measured truth table and compares it with an expected
// table. Sits between the lab control logic (start/result) and the gate datapath.
//
// PARAMETERS
// N_IN          2   number of gate inputs; table width TT_W = 2**N_IN
// SETTLE_CYCLES 2   cycles gate_in is held before z is sampled; legal range 1..15
// ERR_W         8   width of err_cnt (optional feature only)
//
// PORTS
// clk      in   1      rising-edge clock
// rst      in   1      asynchronous, active-high reset
// start    in   1      request a scan; accepted only in IDLE
// exp_tt   in   TT_W   expected table; bit i = expected z for gate_in == i
// gate_out in   1      z from gate under test
// gate_in  out  N_IN   drive to gate; MSB = x, LSB = y for N_IN = 2
// busy     out  1      high from the cycle after start is accepted until DONE
// done     out  1      single-cycle pulse: scan complete, tt/pass valid
// tt       out  TT_W   measured table; bit i = sampled z for vector i
// pass     out  1      tt == exp_tt, as captured at start
// err_cnt  out  ERR_W  failed-scan count (only with TT_ERRCNT_EN)
//
// BEHAVIOUR
// - Reset (async, any state): state IDLE; gate_in=0, busy=0, done=0, tt=0, pass=0,
//   idx=0, settle counter=0, exp register=0, err_cnt=0.
// - All outputs registered; gate_in = idx register directly.
// - FSM states: IDLE, SETTLE, SAMPLE, DONE.
//   IDLE:   start=1 -> capture exp_tt, idx<=0, tt<=0, pass<=0, cnt<=SETTLE_CYCLES-1,
//           busy<=1, -> SETTLE. start=0 -> stay; tt/pass hold last result.
//   SETTLE: cnt==0 -> SAMPLE; else cnt<=cnt-1.
//   SAMPLE: tt[idx]<=gate_out. idx==TT_W-1 -> DONE; else idx<=idx+1,
//           cnt<=SETTLE_CYCLES-1, -> SETTLE.
//   DONE:   done=1 for this cycle only; pass<=(tt==exp register) using final tt;
//           busy<=0; -> IDLE. gate_in returns to 0 on entry to IDLE.
// - pass is registered on the DONE->IDLE edge, so valid from first IDLE cycle
//   after done; done and pass therefore must be read as: sample pass when done
//   falls (bench samples one cycle after done).
// - Per vector: SETTLE_CYCLES cycles SETTLE + 1 cycle SAMPLE.
//   Start edge to done=1: TT_W*(SETTLE_CYCLES+1)+1 edges (13 at defaults).
// - start while busy or in DONE: ignored, no effect on scan or results.
// - start held high continuously: new scan begins the cycle after return to IDLE
//   (back-to-back; one IDLE cycle between scans).
// - exp_tt changes mid-scan: no effect (captured copy used).
// - rst mid-scan: immediate abort, all reset values; no done pulse.
// - idx never wraps: SAMPLE at TT_W-1 always exits to DONE.
//
// CONFIGURATION
// TT_ERRCNT_EN defined: err_cnt increments by 1 in the cycle pass is written 0;
//   saturates at 2**ERR_W-1; cleared only by rst.
// TT_ERRCNT_EN undefined: err_cnt port absent; no counter logic.
//
// TESTING (bench models gate behaviourally from gate_in; defaults)
// 1 AND gate, exp_tt=4'b1000, pulse start -> gate_in 0,1,2,3 each 3 cycles;
//   done 13 edges after start; tt=4'b1000, pass=1, busy 0 after done.
// 2 AND gate, exp_tt=4'b0110 -> tt=4'b1000, pass=0; err_cnt=1 with TT_ERRCNT_EN.
// 3 XOR gate, exp_tt=4'b0110; pulse start again at cycle 5 of scan -> single done,
//   tt=4'b0110, pass=1; exp_tt changed to 0 mid-scan -> still pass=1.
// 4 Assert rst during vector 2 of a scan -> gate_in=0, busy=0, tt=0, pass=0,
//   no done; subsequent start completes normally.
// 5 start held high, OR gate, exp_tt=4'b1110 -> consecutive done pulses 14 edges
//   apart, each with tt=4'b1110, pass=1.
// 6 TT_ERRCNT_EN, ERR_W=2: five failing scans -> err_cnt 1,2,3,3,3.

Source files
------------

// File: rtl/gate_tt_scanner.sv
// Truth-table scanner for a small combinational gate: walks gate_in through every vector,
// samples gate_out after a settle delay and compares the table. Optional macro: TT_ERRCNT_EN.
module gate_tt_scanner #(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8,
  localparam int TT_W         = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [TT_W-1:0] exp_tt,
  input  logic            gate_out,
  output logic [N_IN-1:0] gate_in,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt,
  output logic            pass
`ifdef TT_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0]      CNT_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
    $error("gate_tt_scanner: SETTLE_CYCLES must be in 1..15");
  end
  if (ERR_W < 1) begin : g_bad_err_w
    $error("gate_tt_scanner: ERR_W must be at least 1");
  end

  state_t          r_state;
  state_t          w_state_next;
  logic [N_IN-1:0] r_idx;
  logic [N_IN-1:0] w_idx_next;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_next;
  logic            r_busy;
  logic            w_busy_next;
  logic            r_done;
  logic            w_done_next;
  logic            r_pass;
  logic            w_pass_next;
  logic [TT_W-1:0] r_exp;
  logic [TT_W-1:0] w_exp_next;
  logic [TT_W-1:0] r_tt;
  logic [TT_W-1:0] w_tt_next;
  logic            w_tt_clear;
  logic            w_tt_we;
  logic            w_match;

  assign w_match = (r_tt == r_exp);

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_pass_next  = r_pass;
    w_exp_next   = r_exp;
    w_tt_clear   = 1'b0;
    w_tt_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_exp_next   = exp_tt;
          w_idx_next   = '0;
          w_tt_clear   = 1'b1;
          w_pass_next  = 1'b0;
          w_cnt_next   = CNT_LOAD;
          w_busy_next  = 1'b1;
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_SAMPLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_SAMPLE: begin
        w_tt_we = 1'b1;
        // idx stops at the last vector, so it can never wrap into a second pass
        if (r_idx == IDX_LAST) begin
          w_done_next  = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_idx_next   = r_idx + 1'b1;
          w_cnt_next   = CNT_LOAD;
          w_state_next = S_SETTLE;
        end
      end
      S_DONE: begin
        w_pass_next  = w_match;
        w_busy_next  = 1'b0;
        w_idx_next   = '0;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Each table bit only listens to gate_out while its own vector is being sampled.
  for (genvar gi = 0; gi < TT_W; gi++) begin : g_tt_bit
    assign w_tt_next[gi] = w_tt_clear ? 1'b0 :
                           ((w_tt_we && (r_idx == N_IN'(gi))) ? gate_out : r_tt[gi]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_exp   <= '0;
      r_tt    <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_pass  <= w_pass_next;
      r_exp   <= w_exp_next;
      r_tt    <= w_tt_next;
    end
  end

  assign gate_in = r_idx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign tt      = r_tt;
  assign pass    = r_pass;

`ifdef TT_ERRCNT_EN
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_err_inc;

  // Counts on the same edge that writes a failing pass result; sticks at all-ones.
  assign w_err_inc = (r_state == S_DONE) && !w_match && (r_err_cnt != {ERR_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_err_inc) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
